// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: load-use / MDU stalls, branch and jump flushes, MDU scheduling.
// Latency: flush/stall/PC controls are combinational; Md_Busy, Md_Done and Stall_Count are registered.
// Backpressure: a stall holds PC and IF/ID and injects a bubble into EX until the hazard clears.
module hazard_stall_ctrl #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 33,
  parameter int CNT_W       = 6,
  parameter int STALL_W     = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [4:0]         ID_rs,
  input  logic [4:0]         ID_rt,
  input  logic               ID_UsesRs,
  input  logic               ID_UsesRt,
  input  logic               ID_Jump,
  input  logic               ID_MdStart,
  input  logic               ID_MdIsDiv,
  input  logic               ID_MdRead,
  input  logic               EX_MemRead,
  input  logic [4:0]         EX_Write_register,
  input  logic               EX_BranchTaken,
  output logic               PC_Write,
  output logic               IF_ID_Write,
  output logic               IF_Flush,
  output logic               ID_Flush,
  output logic               Md_Start,
  output logic               Md_Busy,
  output logic               Md_Done,
  output logic [STALL_W-1:0] Stall_Count
);

  typedef enum logic {IDLE, BUSY} md_state_e;

  // Countdown reload values: busy lasts N cycles, counting N-1 down to 0.
  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES - 1);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic               lu, md;

  assign Md_Busy     = (state_q == BUSY);
  assign Md_Done     = done_q;
  assign Stall_Count = stall_cnt_q;

  // Hazard detection: load-use against a non-zero destination, or MDU access while busy.
  always_comb begin
    lu = EX_MemRead && (EX_Write_register != 5'd0) &&
         ((ID_UsesRs && (ID_rs == EX_Write_register)) ||
          (ID_UsesRt && (ID_rt == EX_Write_register)));
    md = Md_Busy && (ID_MdRead || ID_MdStart);
  end

  // Pipeline control priority: reset, taken branch, stall, jump, normal flow.
  always_comb begin
    PC_Write    = 1'b1;
    IF_ID_Write = 1'b1;
    IF_Flush    = 1'b0;
    ID_Flush    = 1'b0;
    if (!reset) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      ID_Flush    = 1'b1;
    end else if (EX_BranchTaken) begin
      IF_Flush = 1'b1;
      ID_Flush = 1'b1;
    end else if (lu || md) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      ID_Flush    = 1'b1;
    end else if (ID_Jump) begin
      IF_Flush = 1'b1;
    end
  end

  // MDU scheduler: a start issues only from IDLE and only when ID is not squashed or stalled.
  // Busy state ignores taken branches since the in-flight op is older than the branch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    Md_Start = 1'b0;
    case (state_q)
      IDLE: begin
        if (reset && ID_MdStart && !EX_BranchTaken && !lu) begin
          Md_Start = 1'b1;
          state_d  = BUSY;
          cnt_d    = ID_MdIsDiv ? DIV_LD : MULT_LD;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Saturating count of cycles in which the PC did not advance.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!PC_Write && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_W'(1);
    end
  end

  // State, countdown, done pulse and performance counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
